// File: rtl/bp_mon_pkg.sv
// bp_mon_pkg: shared definitions for the tournament branch predictor
// protocol monitor.
//   - error flag bit positions in err / first_err.index
//   - first_err record layout {valid, index}
//   - default values for the monitor width parameters
//   - lowest_err(): index of the lowest set error bit
package bp_mon_pkg;

    localparam int ERR_PC_UNSTABLE = 0;
    localparam int ERR_LHT_LATE    = 1;
    localparam int ERR_OVERFLOW    = 2;
    localparam int ERR_UNDERFLOW   = 3;
    localparam int NUM_ERR         = 4;

    localparam int DEF_PC_W       = 10;
    localparam int DEF_HIST_W     = 10;
    localparam int DEF_STABLE_CYC = 8;
    localparam int DEF_DEPTH      = 4;
    localparam int DEF_CNT_W      = 16;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } first_err_t;

    // When several errors fire in one cycle the lowest index is reported.
    function automatic logic [1:0] lowest_err(input logic [NUM_ERR-1:0] fire);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ERR - 1; i >= 0; i--) begin
            if (fire[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bp_mon_fifo.sv
// bp_mon_fifo: synchronous DEPTH x 1 FIFO holding outstanding predicted
// directions for the scoreboard.
// Ports:
//   clock      in   posedge clock
//   reset      in   synchronous, active-low
//   push       in   write push_data (dropped when full unless popping too)
//   push_data  in   predicted direction
//   pop        in   remove oldest entry (ignored when empty)
//   head       out  oldest entry (valid when !empty)
//   full       out  DEPTH entries held
//   empty      out  no entries held
//   occupancy  out  number of entries held
module bp_mon_fifo
    import bp_mon_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   push_data,
    input  logic                   pop,
    output logic                   head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (!reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign occupancy = count;

endmodule

// File: rtl/bp_protocol_monitor.sv
// bp_protocol_monitor: passive protocol monitor and scoreboard for the
// tournament branch predictor. Flags unstable fetch PCs, late LHT results and
// prediction FIFO overflow/underflow, and counts scored and mispredicted
// branches.
// Ports:
//   clock          in   posedge clock
//   reset          in   synchronous, active-low
//   clr            in   clears err, first_err and both counters
//   pc             in   fetch PC
//   lht_valid      in   LHT result qualifier
//   lht_result     in   LHT result (only its qualification is checked)
//   pred_valid     in   prediction issued
//   pred_taken     in   predicted direction
//   resolve_valid  in   in-order branch resolution
//   resolve_taken  in   actual direction
//   err            out  sticky flags {underflow, overflow, lht_late, pc_unstable}
//   first_err      out  {valid, index} of first error since reset/clr
//   pred_cnt       out  scored predictions (saturating)
//   mispred_cnt    out  mispredictions (saturating)
//   occupancy      out  outstanding predictions
module bp_protocol_monitor
    import bp_mon_pkg::*;
#(
    parameter int PC_W       = DEF_PC_W,
    parameter int HIST_W     = DEF_HIST_W,
    parameter int STABLE_CYC = DEF_STABLE_CYC,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clr,
    input  logic [PC_W-1:0]        pc,
    input  logic                   lht_valid,
    input  logic [HIST_W-1:0]      lht_result,
    input  logic                   pred_valid,
    input  logic                   pred_taken,
    input  logic                   resolve_valid,
    input  logic                   resolve_taken,
    output logic [NUM_ERR-1:0]     err,
    output logic [2:0]             first_err,
    output logic [CNT_W-1:0]       pred_cnt,
    output logic [CNT_W-1:0]       mispred_cnt,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int HOLD_W = $clog2(STABLE_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PC_W-1:0]    pc_prev;
    logic               pc_prev_valid;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               chg_d;
    logic               pc_change;
    logic [NUM_ERR-1:0] fire;
    logic [NUM_ERR-1:0] err_q;
    first_err_t         first_q;
    logic [CNT_W-1:0]   pred_cnt_q;
    logic [CNT_W-1:0]   mispred_cnt_q;

    logic fifo_head;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_push;
    logic fifo_pop;
    logic bypass;
    logic score_valid;
    logic score_pred;

    // Only the qualifier is checked; the history value itself is not.
    logic unused_lht;
    assign unused_lht = ^lht_result;

    assign pc_change = pc_prev_valid && (pc != pc_prev);

    // Push and pop into an empty FIFO: score the incoming prediction directly.
    assign bypass      = fifo_empty && pred_valid && resolve_valid;
    assign fifo_push   = pred_valid && !bypass;
    assign fifo_pop    = resolve_valid && !fifo_empty;
    assign score_valid = resolve_valid && (pred_valid || !fifo_empty);
    assign score_pred  = fifo_empty ? pred_taken : fifo_head;

    always_comb begin
        fire                  = '0;
        fire[ERR_PC_UNSTABLE] = pc_change && (hold_cnt != '0);
        fire[ERR_LHT_LATE]    = chg_d && !lht_valid;
        fire[ERR_OVERFLOW]    = pred_valid && !resolve_valid && fifo_full;
        fire[ERR_UNDERFLOW]   = resolve_valid && !pred_valid && fifo_empty;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_prev       <= '0;
            pc_prev_valid <= 1'b0;
            hold_cnt      <= '0;
            chg_d         <= 1'b0;
            err_q         <= '0;
            first_q       <= '0;
            pred_cnt_q    <= '0;
            mispred_cnt_q <= '0;
        end else begin
            pc_prev       <= pc;
            pc_prev_valid <= 1'b1;
            chg_d         <= pc_change;

            // Any change restarts the hold window, whether or not it was legal.
            if (pc_change) begin
                hold_cnt <= HOLD_LOAD;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end

            // A new error in the clearing cycle survives the clear.
            err_q <= (clr ? '0 : err_q) | fire;
            if ((fire != '0) && (clr || !first_q.valid)) begin
                first_q <= '{valid: 1'b1, idx: lowest_err(fire)};
            end else if (clr) begin
                first_q <= '0;
            end

            if (clr) begin
                pred_cnt_q    <= '0;
                mispred_cnt_q <= '0;
            end else if (score_valid) begin
                if (pred_cnt_q != CNT_MAX) begin
                    pred_cnt_q <= pred_cnt_q + 1'b1;
                end
                if ((score_pred != resolve_taken) && (mispred_cnt_q != CNT_MAX)) begin
                    mispred_cnt_q <= mispred_cnt_q + 1'b1;
                end
            end
        end
    end

    bp_mon_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (pred_taken),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

    assign err         = err_q;
    assign first_err   = first_q;
    assign pred_cnt    = pred_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule
